// File: rtl/keypad_scan_controller.sv
// 4x4 matrix keypad scanner: rotating one-hot column drive, synchronized active-low rows,
// press/release debounce, one key_valid pulse per accepted key.
module keypad_scan_controller #(
    parameter int SCAN_DIV     = 4096,
    parameter int DEBOUNCE_CNT = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_n,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t        state, state_nx;
    logic [3:0]    sync1, sync2, row_act;
    logic [DW-1:0] dwell, dwell_nx;
    logic [BW-1:0] deb, deb_nx;
    logic [3:0]    cols_nx, code_nx;
    logic [1:0]    row_idx, row_idx_nx, col_idx, col_idx_nx;
    logic [1:0]    act_idx, cols_idx;
    logic          valid_nx, held_nx;
    logic          one_hot, row_match, row_on;

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] i;
        case (v)
            4'b0010: i = 2'd1;
            4'b0100: i = 2'd2;
            4'b1000: i = 2'd3;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= rows_n;
            sync2 <= sync1;
        end
    end

    assign row_act   = ~sync2;
    assign one_hot   = (row_act != 4'd0) && ((row_act & (row_act - 4'd1)) == 4'd0);
    assign act_idx   = enc4(row_act);
    assign cols_idx  = enc4(cols);
    assign row_match = (row_act == (4'b0001 << row_idx));
    assign row_on    = row_act[row_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_SCAN;
            cols      <= 4'b0001;
            dwell     <= '0;
            deb       <= '0;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            cols      <= cols_nx;
            dwell     <= dwell_nx;
            deb       <= deb_nx;
            row_idx   <= row_idx_nx;
            col_idx   <= col_idx_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cols_nx    = cols;
        dwell_nx   = dwell;
        deb_nx     = deb;
        row_idx_nx = row_idx;
        col_idx_nx = col_idx;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        held_nx    = key_held;
        case (state)
            S_SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    if (one_hot) begin
                        // Freeze the column so the debounce watches the same key
                        row_idx_nx = act_idx;
                        col_idx_nx = cols_idx;
                        deb_nx     = '0;
                        state_nx   = S_DEBOUNCE;
                    end else begin
                        cols_nx = {cols[2:0], cols[3]};
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (!row_match) begin
                    cols_nx  = {cols[2:0], cols[3]};
                    dwell_nx = '0;
                    deb_nx   = '0;
                    state_nx = S_SCAN;
                end else if (deb == DEB_LAST) begin
                    valid_nx = 1'b1;
                    held_nx  = 1'b1;
                    code_nx  = keymap(row_idx, col_idx);
                    deb_nx   = '0;
                    state_nx = S_HELD;
                end else begin
                    deb_nx = deb + 1'b1;
                end
            end
            S_HELD: begin
                if (!row_on) begin
                    deb_nx   = '0;
                    state_nx = S_RELEASE;
                end
            end
            default: begin
                if (row_on) begin
                    deb_nx   = '0;
                    state_nx = S_HELD;
                end else if (deb == DEB_LAST) begin
                    held_nx  = 1'b0;
                    cols_nx  = {cols[2:0], cols[3]};
                    dwell_nx = '0;
                    deb_nx   = '0;
                    state_nx = S_SCAN;
                end else begin
                    deb_nx = deb + 1'b1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_keypad_scan_controller.sv
// Keypad model + directed and randomized presses; expected key codes are queued at stimulus
// time and a forked monitor pops one per key_valid pulse.
module tb_keypad_scan_controller;
    localparam int SD = 4;
    localparam int DB = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       rows_n, cols, key_code;
    logic             key_valid, key_held;
    logic [3:0][3:0]  pressed;  // pressed[r][c]
    logic [3:0]       keymap [4][4];
    logic [3:0]       exp_q [$];
    int               n_tests = 0;
    int               n_fail = 0;

    keypad_scan_controller #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk), .reset(reset), .rows_n(rows_n), .cols(cols),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // A row is pulled low when any pressed key in it sits in a driven column
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++) rows_n[r] = ~|(pressed[r] & cols);
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic v, input int maxc, input string name);
        int i;
        i = 0;
        while (key_held !== v && i < maxc) begin
            @(negedge clk);
            i++;
        end
        check(name, {3'b0, key_held}, {3'b0, v});
    endtask

    task automatic wait_cols(input logic [3:0] v, input int maxc);
        int i;
        i = 0;
        while (cols !== v && i < maxc) begin
            @(negedge clk);
            i++;
        end
        check("wait_cols", cols, v);
    endtask

    task automatic monitor();
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: key_code %h, no pulse expected at %0t", key_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_code", key_code, e);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int r, c, dur;
        bit lng;
        keymap[0] = '{4'h1, 4'h2, 4'h3, 4'hA};
        keymap[1] = '{4'h4, 4'h5, 4'h6, 4'hB};
        keymap[2] = '{4'h7, 4'h8, 4'h9, 4'hC};
        keymap[3] = '{4'hE, 4'h0, 4'hF, 4'hD};
        pressed = '0;
        fork
            monitor();
        join_none

        // Reset values, then free scan: column k/4 after the k-th edge past release
        cycles(3);
        check("rst_cols", cols, 4'b0001);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'h0);
        check("rst_held", {3'b0, key_held}, 4'h0);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("scan_cols", cols, 4'b0001 << ((k / SD) % 4));
        end

        // Key 5 for 40 cycles; column frozen while held
        exp_q.push_back(keymap[1][1]);
        pressed[1][1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_held) check("k5_frozen", cols, 4'b0010);
        end
        check("k5_held", {3'b0, key_held}, 4'h1);
        check("k5_code", key_code, 4'h5);
        pressed[1][1] = 1'b0;
        // 2 sync edges + 1 edge into RELEASE + DB counting edges
        cycles(2 + DB);
        check("k5_held_before_fall", {3'b0, key_held}, 4'h1);
        cycles(1);
        check("k5_held_fall", {3'b0, key_held}, 4'h0);
        check("k5_resume_cols", cols, 4'b0100);

        // Key D bounce of 3 cycles lined up with column 3's terminal count
        wait_cols(4'b0100, 4 * SD);
        wait_cols(4'b1000, 4 * SD);
        pressed[3][3] = 1'b1;
        cycles(3);
        pressed[3][3] = 1'b0;
        cycles(2);
        check("bounce_frozen", cols, 4'b1000);
        cycles(1);
        check("bounce_resume", cols, 4'b0001);
        check("bounce_code", key_code, 4'h5);

        // Key A with a 3-cycle release bounce, then clean release
        cycles(20);
        exp_q.push_back(keymap[0][3]);
        pressed[0][3] = 1'b1;
        wait_held(1'b1, 40, "a_accept");
        cycles(3);
        pressed[0][3] = 1'b0;
        cycles(3);
        pressed[0][3] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("a_bounce_held", {3'b0, key_held}, 4'h1);
        end
        pressed[0][3] = 1'b0;
        cycles(12);
        check("a_release", {3'b0, key_held}, 4'h0);
        check("a_code", key_code, 4'hA);

        // Keys 3 and 9 share column 2: never accepted
        cycles(4);
        pressed[0][2] = 1'b1;
        pressed[2][2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("multi_row_held", {3'b0, key_held}, 4'h0);
        end
        pressed = '0;
        cycles(4);

        // Keys 1 and 6 together from the start of column 0: only 1 reported
        wait_cols(4'b1000, 4 * SD);
        wait_cols(4'b0001, 4 * SD);
        exp_q.push_back(keymap[0][0]);
        pressed[0][0] = 1'b1;
        pressed[1][2] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (key_held) check("k1_frozen", cols, 4'b0001);
        end
        check("k1_code", key_code, 4'h1);
        pressed = '0;
        cycles(14);
        check("k1_release", {3'b0, key_held}, 4'h0);

        // Async reset mid-HELD, then re-acceptance with key still down
        cycles(4);
        exp_q.push_back(keymap[2][0]);
        pressed[2][0] = 1'b1;
        wait_held(1'b1, 40, "r_accept");
        cycles(2);
        #2 reset = 1'b0;
        #1;
        check("arst_cols", cols, 4'b0001);
        check("arst_held", {3'b0, key_held}, 4'h0);
        check("arst_code", key_code, 4'h0);
        check("arst_valid", {3'b0, key_valid}, 4'h0);
        cycles(2);
        reset = 1'b1;
        exp_q.push_back(keymap[2][0]);
        wait_held(1'b1, 40, "r_reaccept");
        check("r_code", key_code, 4'h7);
        pressed = '0;
        cycles(14);

        // Random keys: short taps (<= 7 cycles) are never accepted, long holds once
        for (int n = 0; n < 16; n++) begin
            r   = $urandom_range(0, 3);
            c   = $urandom_range(0, 3);
            lng = 1'($urandom_range(0, 1));
            dur = lng ? $urandom_range(40, 70) : $urandom_range(1, 7);
            cycles($urandom_range(0, 5));
            if (lng) exp_q.push_back(keymap[r][c]);
            pressed[r][c] = 1'b1;
            cycles(dur);
            pressed[r][c] = 1'b0;
            cycles(20);
            check("rand_held_low", {3'b0, key_held}, 4'h0);
            if (lng) check("rand_code", key_code, keymap[r][c]);
        end

        cycles(5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulse: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencer for the 4x4 matrix keypad. It rotates a one-hot column drive, samples the active-low row lines through a synchronizer, and debounces press and release. Each debounced press emits exactly one single-cycle `key_valid` pulse with a 4-bit hex code. The block sits between the keypad pins and the key-history/display logic, and replaces free-running column phase generation with a scan that freezes while a key is being qualified or held.

## Interface

Parameters:
- `SCAN_DIV`, default 4096: cycles each column stays driven while scanning. Must be at least 4.
- `DEBOUNCE_CNT`, default 65536: consecutive stable cycles required to accept a press or a release. Must be at least 2.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: active-low asynchronous reset. The block has one clock; reset is asynchronous and active-low.
- `rows_n`, input, 4: raw keypad row lines, pulled up. `rows_n[r]=0` means a key in row r of the driven column is closed.
- `cols`, output, 4: one-hot column drive, active-high. `cols[c]=1` drives column c.
- `key_code`, output, 4: hex code of the last accepted key. Holds its value until the next accepted press.
- `key_valid`, output, 1: one-cycle pulse marking acceptance of a new key.
- `key_held`, output, 1: high from acceptance until the release is debounced.

## Operation

- Rows pass through a 2-flop synchronizer, reset value 4'b1111. `row_act = ~sync_rows`.
- Key map, row r / column c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- SCAN state:
  - Dwell counter counts 0..SCAN_DIV-1. At the terminal count, `cols` rotates left: 0001→0010→0100→1000→0001.
  - `row_act` is sampled only on the terminal-count cycle, before rotation.
  - If exactly one bit of `row_act` is set: latch row index and column index, hold `cols`, clear the counter, go to DEBOUNCE.
  - If zero bits or two or more bits are set: rotate normally. Multiple rows in one column are ignored.
- DEBOUNCE state:
  - Each cycle, if `row_act` equals the latched one-hot row, the counter increments. Otherwise go to SCAN, rotating `cols` to the next column and clearing the dwell counter.
  - When the counter reaches DEBOUNCE_CNT-1 with a match: next cycle set `key_valid=1`, `key_held=1`, and load `key_code` from the map. Go to HELD.
- HELD state:
  - `cols` stays frozen.
  - When the latched row goes inactive, clear the counter and go to RELEASE.
  - Other rows asserting (a second key) are ignored.
- RELEASE state:
  - Each cycle the latched row is inactive, the counter increments. If the latched row reasserts, go back to HELD with no new pulse.
  - At DEBOUNCE_CNT-1 inactive cycles: `key_held=0`, go to SCAN. `cols` rotates to the next column and the dwell counter clears.
- Reset at any time, including mid-DEBOUNCE or mid-HELD: all state clears immediately and no pulse is emitted.

## Timing

- Reset values: `cols`=4'b0001, `key_code`=4'h0, `key_valid`=0, `key_held`=0, state SCAN, all counters 0, synchronizer 4'b1111.
- Scanning: each column is driven for exactly SCAN_DIV cycles. A full sweep takes 4·SCAN_DIV cycles.
- Row path: a pin change reaches `row_act` after 2 clock edges.
- Press acceptance: `key_valid` rises exactly DEBOUNCE_CNT cycles after the first DEBOUNCE cycle. It is high for exactly 1 cycle. `key_code` and `key_held` update on the same edge.
- Release: `key_held` falls exactly DEBOUNCE_CNT cycles after the first RELEASE cycle. Scanning resumes on that same edge.
- Only one accepted key at a time. A second key pressed during HELD is never reported, even after the first key releases, unless it is re-detected by a later scan.
- Counters are sized to `$clog2` of their parameter. They never wrap; they are cleared at every state entry.

## Test plan

Use `SCAN_DIV=4` and `DEBOUNCE_CNT=8`. The bench models the keypad: `rows_n[r]=0` while `cols[c]=1` and key (r,c) is pressed.

- Reset, no keys: `cols`=0001 and all outputs are 0. `cols` reads 0010, 0100, 1000, 0001 at cycles 4, 8, 12, 16 after reset release. `key_valid` never pulses.
- Press key 5 (r1,c1) for 40 cycles: exactly one `key_valid` pulse with `key_code`=4'h5. `cols` is frozen at 0010 while `key_held=1`. `key_held` falls 8 cycles after release is seen, then `cols` goes to 0100.
- Bouncy press of key D (r3,c3) lasting 3 cycles: no `key_valid`, `key_code` unchanged. Scan resumes at 0001.
- Release bounce on held key A (r0,c3):
  - Drop the row for 3 cycles, then reassert: no second pulse, `key_held` stays 1.
  - Then a clean release of at least 10 cycles: `key_held`=0.
- Keys 3 (r0,c2) and 9 (r2,c2) pressed together: no pulse. Keys 1 (r0,c0) and 6 (r1,c2) pressed together: only 4'h1 is reported. No 4'h6 pulse while 1 is held.
- Assert `reset` low mid-HELD: `key_held`=0, `key_code`=0, and `cols`=0001 immediately, without waiting for a clock edge. After reset is released with the key still down, a fresh press is reported once.
